// File: rtl/dtu_pkg.sv
// Shared constants, packer state type and baseline detection for the LiTe-DTU word packer.
package dtu_pkg;

  localparam logic [1:0]  HDR_BASE5   = 2'b01;
  localparam logic [1:0]  HDR_BASEN   = 2'b10;
  localparam logic [5:0]  HDR_SIG2    = 6'b001010;
  localparam logic [6:0]  HDR_SIG1    = 7'b0010110;
  localparam logic [3:0]  HDR_TRAILER = 4'b1101;

  localparam logic [31:0] IDLE_WORD = 32'hEAAAAAAA;
  localparam logic [31:0] SYNC_WORD = 32'h35555555;

  typedef enum logic [1:0] {
    PK_EMPTY,
    PK_BASE,
    PK_SIG1P
  } pk_state_e;

  // A sample fits a 6-bit field only at gain x10 with a small amplitude.
  function automatic logic is_baseline(input logic [12:0] s);
    return (s[12] == 1'b0) && (s[11:6] == 6'b000000);
  endfunction

endpackage

// File: rtl/dtu_word_packer_if.sv
// Sample-in / word-out bus of the DTU word packer; master drives samples and read requests.
interface dtu_word_packer_if;
  logic [12:0] din;
  logic        din_valid;
  logic        flush;
  logic        word_rd;
  logic [31:0] word_out;
  logic        fifo_full;
  logic        overflow;

  modport master (
    output din, din_valid, flush, word_rd,
    input  word_out, fifo_full, overflow
  );

  modport slave (
    input  din, din_valid, flush, word_rd,
    output word_out, fifo_full, overflow
  );
endinterface

// File: rtl/dtu_word_fifo.sv
// Synchronous show-ahead word FIFO; a push into a full FIFO is accepted when a pop frees the slot.
module dtu_word_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_160,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_160) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_160) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dtu_word_packer.sv
// LiTe-DTU word packer: packs 13-bit samples into 32-bit words, buffers them, and serves SYNC/IDLE/data.
// Optional frame trailer insertion is enabled with the DTU_TRAILER_EN macro.
module dtu_word_packer
  import dtu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_WORDS  = 8,
  parameter int FRAME_WORDS = 50
) (
  input  logic              clk_160,
  input  logic              rst,
  dtu_word_packer_if.slave  bus
);

  localparam int SCW = (SYNC_WORDS < 1) ? 1 : $clog2(SYNC_WORDS + 1);

  function automatic logic [31:0] basen_word(input logic [2:0] k, input logic [23:0] fields);
    return {HDR_BASEN, 2'b00, 1'b0, k, fields};
  endfunction

  function automatic logic [31:0] sig1_word(input logic [12:0] a);
    return {HDR_SIG1, 12'h000, a};
  endfunction

  pk_state_e   state_q, state_s, state_n;
  logic [2:0]  k_q, k_s, k_n;
  logic [23:0] base_buf_q, base_buf_s;
  logic [12:0] sig_q, sig_s;
  logic        flush_pend_q, flush_pend_n;
  logic        push_s, push;
  logic [31:0] word_s, push_word;
  logic        is_base;

  logic [31:0] fifo_rdata;
  logic        fifo_full, fifo_empty, pop, drop;
  logic [SCW-1:0] sync_cnt_q;
  logic [31:0] word_out_q;
  logic        overflow_q;

  assign is_base = is_baseline(bus.din);

  // Stage p0: sample absorption, then flush of whatever partial word remains
  always_comb begin
    state_s    = state_q;
    k_s        = k_q;
    base_buf_s = base_buf_q;
    sig_s      = sig_q;
    push_s     = 1'b0;
    word_s     = '0;
    if (bus.din_valid) begin
      case (state_q)
        PK_EMPTY: begin
          if (is_base) begin
            state_s    = PK_BASE;
            k_s        = 3'd1;
            base_buf_s = {18'b0, bus.din[5:0]};
          end else begin
            state_s = PK_SIG1P;
            sig_s   = bus.din;
          end
        end
        PK_BASE: begin
          if (is_base) begin
            if (k_q == 3'd4) begin
              push_s  = 1'b1;
              word_s  = {HDR_BASE5, bus.din[5:0], base_buf_q};
              state_s = PK_EMPTY;
              k_s     = 3'd0;
            end else begin
              case (k_q)
                3'd1:    base_buf_s[11:6]  = bus.din[5:0];
                3'd2:    base_buf_s[17:12] = bus.din[5:0];
                default: base_buf_s[23:18] = bus.din[5:0];
              endcase
              k_s = k_q + 3'd1;
            end
          end else begin
            push_s  = 1'b1;
            word_s  = basen_word(k_q, base_buf_q);
            state_s = PK_SIG1P;
            k_s     = 3'd0;
            sig_s   = bus.din;
          end
        end
        PK_SIG1P: begin
          if (is_base) begin
            push_s     = 1'b1;
            word_s     = sig1_word(sig_q);
            state_s    = PK_BASE;
            k_s        = 3'd1;
            base_buf_s = {18'b0, bus.din[5:0]};
          end else begin
            push_s  = 1'b1;
            word_s  = {HDR_SIG2, bus.din, sig_q};
            state_s = PK_EMPTY;
          end
        end
        default: state_s = PK_EMPTY;
      endcase
    end

    state_n      = state_s;
    k_n          = k_s;
    push         = push_s;
    push_word    = word_s;
    flush_pend_n = 1'b0;
    // Only one word may be pushed per cycle, so a flush that collides with a push waits a cycle.
    if ((bus.flush || flush_pend_q) && (state_s != PK_EMPTY)) begin
      if (push_s) begin
        flush_pend_n = 1'b1;
      end else begin
        push      = 1'b1;
        push_word = (state_s == PK_BASE) ? basen_word(k_s, base_buf_s) : sig1_word(sig_s);
        state_n   = PK_EMPTY;
        k_n       = 3'd0;
      end
    end
  end

  always_ff @(posedge clk_160) begin
    if (!rst) begin
      state_q      <= PK_EMPTY;
      k_q          <= 3'd0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      k_q          <= k_n;
      flush_pend_q <= flush_pend_n;
    end
  end

  always_ff @(posedge clk_160) begin
    base_buf_q <= base_buf_s;
    sig_q      <= sig_s;
  end

  dtu_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_160 (clk_160),
    .rst     (rst),
    .push    (push),
    .wdata   (push_word),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign drop = push && fifo_full && !pop;

`ifdef DTU_TRAILER_EN
  localparam int FCW = $clog2(FRAME_WORDS + 1);

  function automatic logic [11:0] word_nsamp(input logic [31:0] w);
    if (w[31:30] == HDR_BASE5)     return 12'd5;
    else if (w[31:30] == HDR_BASEN) return {8'b0, w[27:24]};
    else if (w[31:26] == HDR_SIG2)  return 12'd2;
    else                            return 12'd1;
  endfunction

  logic [FCW-1:0] frame_cnt_q;
  logic           trailer_due_q;
  logic [7:0]     frame_id_q;
  logic [11:0]    nsamp_q;
  logic           trailer_rd;

  assign pop        = bus.word_rd && (sync_cnt_q == '0) && !trailer_due_q && !fifo_empty;
  assign trailer_rd = bus.word_rd && (sync_cnt_q == '0) && trailer_due_q;

  always_ff @(posedge clk_160) begin
    if (!rst) begin
      frame_cnt_q   <= '0;
      trailer_due_q <= 1'b0;
      frame_id_q    <= 8'd0;
      nsamp_q       <= 12'd0;
    end else if (trailer_rd) begin
      trailer_due_q <= 1'b0;
      frame_id_q    <= frame_id_q + 8'd1;
      nsamp_q       <= 12'd0;
    end else if (pop) begin
      nsamp_q <= nsamp_q + word_nsamp(fifo_rdata);
      if (frame_cnt_q == FCW'(FRAME_WORDS - 1)) begin
        frame_cnt_q   <= '0;
        trailer_due_q <= 1'b1;
      end else begin
        frame_cnt_q <= frame_cnt_q + FCW'(1);
      end
    end
  end
`else
  assign pop = bus.word_rd && (sync_cnt_q == '0) && !fifo_empty;
`endif

  // Stage p1: serializer-facing word register, updated only on a read request
  always_ff @(posedge clk_160) begin
    if (!rst) begin
      sync_cnt_q <= SCW'(SYNC_WORDS);
      word_out_q <= SYNC_WORD;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | drop;
      if (bus.word_rd) begin
        if (sync_cnt_q != '0) begin
          word_out_q <= SYNC_WORD;
          sync_cnt_q <= sync_cnt_q - SCW'(1);
`ifdef DTU_TRAILER_EN
        end else if (trailer_due_q) begin
          word_out_q <= {HDR_TRAILER, frame_id_q, 8'h00, nsamp_q};
`endif
        end else if (!fifo_empty) begin
          word_out_q <= fifo_rdata;
        end else begin
          word_out_q <= IDLE_WORD;
        end
      end
    end
  end

  assign bus.word_out  = word_out_q;
  assign bus.fifo_full = fifo_full;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_dtu_word_packer.sv
// Scoreboard bench for dtu_word_packer: expected words are queued at each read request and checked by a monitor.
module tb_dtu_word_packer;

`ifdef DTU_TRAILER_EN
  localparam int FW = 2;
`else
  localparam int FW = 50;
`endif

  logic clk_160 = 1'b0;
  logic rst;
  always #3 clk_160 = ~clk_160;

  dtu_word_packer_if ifc();

  dtu_word_packer #(.FIFO_DEPTH(16), .SYNC_WORDS(8), .FRAME_WORDS(FW)) dut (
    .clk_160 (clk_160),
    .rst     (rst),
    .bus     (ifc)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] SYNC = 32'h35555555;
  localparam logic [31:0] IDLE = 32'hEAAAAAAA;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read request presents one word on the following cycle
  initial begin
    forever begin
      @(posedge clk_160);
      if (ifc.word_rd === 1'b1 && rst === 1'b1) begin
        @(negedge clk_160);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_out_unexpected: got %h expected no read", ifc.word_out);
        end else begin
          check("word_out", ifc.word_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic rd(input logic [31:0] e);
    exp_q.push_back(e);
    @(negedge clk_160) ifc.word_rd = 1'b1;
    @(negedge clk_160) ifc.word_rd = 1'b0;
    repeat (3) @(negedge clk_160);
  endtask

  task automatic sample(input logic [12:0] d, input logic fl);
    @(negedge clk_160);
    ifc.din = d;
    ifc.din_valid = 1'b1;
    ifc.flush = fl;
    @(negedge clk_160);
    ifc.din_valid = 1'b0;
    ifc.flush = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk_160) ifc.flush = 1'b1;
    @(negedge clk_160) ifc.flush = 1'b0;
  endtask

  task automatic five_baselines();
    for (int i = 1; i <= 5; i++) sample(13'(i), 1'b0);
  endtask

  initial begin
    logic [12:0] a, b;
    logic [31:0] words [16];
    rst = 1'b0;
    ifc.din = '0;
    ifc.din_valid = 1'b0;
    ifc.flush = 1'b0;
    ifc.word_rd = 1'b0;
    repeat (3) @(negedge clk_160);
    check("reset_word_out", ifc.word_out, SYNC);
    check("reset_overflow", {31'b0, ifc.overflow}, 32'd0);
    check("reset_fifo_full", {31'b0, ifc.fifo_full}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) rd(SYNC);
    rd(IDLE);
    rd(IDLE);

`ifdef DTU_TRAILER_EN
    five_baselines();
    five_baselines();
    rd(32'h45103081);
    rd(32'h45103081);
    rd(32'hD000000A);
    five_baselines();
    five_baselines();
    rd(32'h45103081);
    rd(32'h45103081);
    rd(32'hD010000A);
`else
    // Full BASE5 word: {01, 05, 04, 03, 02, 01}
    five_baselines();
    rd(32'h45103081);

    sample(13'h003F, 1'b0);
    sample(13'h003F, 1'b0);
    sample(13'h1ABC, 1'b0);
    sample(13'h0040, 1'b0);
    rd(32'h82000FFF);
    rd(32'h28081ABC);

    sample(13'h0800, 1'b0);
    do_flush();
    rd(32'h2C000800);
    do_flush();
    rd(IDLE);

    // Flush alongside a sample that pushes: the flush is deferred one cycle
    sample(13'h0800, 1'b0);
    sample(13'h0005, 1'b1);
    rd(32'h2C000800);
    rd(32'h81000005);

    // Flush alongside a sample that does not push: closed in the same cycle
    sample(13'h0001, 1'b0);
    sample(13'h0002, 1'b1);
    rd(32'h82000081);
    rd(IDLE);

    check("pre_overflow", {31'b0, ifc.overflow}, 32'd0);
    check("pre_fifo_full", {31'b0, ifc.fifo_full}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      a = 13'h1000 + 13'(2 * i);
      b = a + 13'd1;
      if (i < 16) words[i] = {6'b001010, b, a};
      sample(a, 1'b0);
      sample(b, 1'b0);
    end
    check("fifo_full", {31'b0, ifc.fifo_full}, 32'd1);
    check("overflow", {31'b0, ifc.overflow}, 32'd1);
    for (int i = 0; i < 16; i++) rd(words[i]);
    rd(IDLE);
    check("fifo_full_drained", {31'b0, ifc.fifo_full}, 32'd0);
    check("overflow_sticky", {31'b0, ifc.overflow}, 32'd1);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_160);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
